// File: rtl/switch_ctrlr_axil_n_pkg.sv
// Shared constants and types for the AXI4-Lite N-channel switch controller.
package switch_ctrlr_pkg;

    // Word index of each register, taken from address bits [4:2].
    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t REG_CTRL  = 3'd0;
    localparam reg_idx_t REG_STATE = 3'd1;
    localparam reg_idx_t REG_MASK  = 3'd2;
    localparam reg_idx_t REG_EVENT = 3'd3;
    localparam reg_idx_t REG_RISE  = 3'd4;
    localparam reg_idx_t REG_FALL  = 3'd5;
    localparam reg_idx_t REG_DEBNC = 3'd6;
    localparam reg_idx_t REG_INFO  = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [15:0] INFO_VERSION = 16'h0002;

    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rd_state_t;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/switch_ctrlr_axil_n_if.sv
// AXI4-Lite bundle between the interconnect (master) and the switch controller (slave).
interface switch_ctrlr_axil_n_if #(
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/switch_ctrlr_axil_n_debounce.sv
// One switch channel: 2-flop synchroniser, programmable debounce, edge detect.
module switch_debounce #(
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             sw_in,
    input  logic [CNT_W-1:0] d_len,
    output logic             sw_state,
    output logic             rise,
    output logic             fall
);

    logic             sync_1;
    logic             sync_2;
    logic             state_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the aclk domain.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync_2 take the old sync_1, giving two real flop stages.
            sync_1 <= sw_in;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level once it has differed for d_len+1 cycles; >= keeps a shortened d_len from wrapping.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt      <= '0;
            sw_state <= 1'b0;
        end else if (sync_2 == sw_state) begin
            cnt <= '0;
        end else if (cnt >= d_len) begin
            cnt      <= '0;
            sw_state <= sync_2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Previous debounced level for edge detection.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= 1'b0;
        else        state_q <= sw_state;
    end

    assign rise = sw_state & ~state_q;
    assign fall = ~sw_state & state_q;

endmodule

// File: rtl/switch_ctrlr_axil_n.sv
// AXI4-Lite controlled N-channel switch controller with sticky events and a level irq.
module switch_ctrlr_axil_n
    import switch_ctrlr_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 5
) (
    input  logic                 aclk,
    input  logic                 areset,
    switch_ctrlr_axil_n_if.slave s_axi,
    input  logic [N_CH-1:0]      sw_in,
    output logic [N_CH-1:0]      sw_state,
    output logic                 irq
);

    wr_state_t        wr_state, wr_next;
    rd_state_t        rd_state, rd_next;
    logic             ctrl_en;
    logic [N_CH-1:0]  mask_q, rise_en, fall_en, event_q;
    logic [N_CH-1:0]  rise, fall, ev_set, ev_w1c;
    logic [CNT_W-1:0] debnc;
    logic [31:0]      be_mask, wr_bits, rd_mux, rdata_q;
    reg_idx_t         wr_idx, rd_idx;
    logic             wr_accept;

    // Low address bits are byte offsets inside a word and carry no decode.
    logic [ADDR_W-1:0] unused_addr;
    logic              unused_data;
    assign unused_addr = s_axi.awaddr ^ s_axi.araddr;
    assign unused_data = ^{be_mask, wr_bits};

    assign wr_idx    = s_axi.awaddr[4:2];
    assign rd_idx    = s_axi.araddr[4:2];
    assign wr_accept = (wr_state == WR_ACCEPT);
    assign be_mask   = strb_mask(s_axi.wstrb);
    assign wr_bits   = s_axi.wdata & be_mask;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        switch_debounce #(.CNT_W(CNT_W)) u_debounce (
            .aclk     (aclk),
            .areset   (areset),
            .sw_in    (sw_in[i]),
            .d_len    (debnc),
            .sw_state (sw_state[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    // Handshake state registers for the independent write and read channels.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Next state: accept for one cycle, then respond until the master takes it.
    always_comb begin
        // NOTE: defaults first on every combinational output so no path infers a latch.
        wr_next = wr_state;
        rd_next = rd_state;
        case (wr_state)
            WR_IDLE:   if (s_axi.awvalid && s_axi.wvalid) wr_next = WR_ACCEPT;
            WR_ACCEPT: wr_next = WR_RESP;
            WR_RESP:   if (s_axi.bready) wr_next = WR_IDLE;
            default:   wr_next = WR_IDLE;
        endcase
        case (rd_state)
            RD_IDLE:   if (s_axi.arvalid) rd_next = RD_ACCEPT;
            RD_ACCEPT: rd_next = RD_DATA;
            RD_DATA:   if (s_axi.rready) rd_next = RD_IDLE;
            default:   rd_next = RD_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state flops.
    always_comb begin
        s_axi.awready = (wr_state == WR_ACCEPT);
        s_axi.wready  = (wr_state == WR_ACCEPT);
        s_axi.bvalid  = (wr_state == WR_RESP);
        s_axi.bresp   = RESP_OKAY;
        s_axi.arready = (rd_state == RD_ACCEPT);
        s_axi.rvalid  = (rd_state == RD_DATA);
        s_axi.rresp   = RESP_OKAY;
        s_axi.rdata   = rdata_q;
    end

    // Byte-masked updates of the RW registers; RO offsets fall through untouched.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ctrl_en <= 1'b0;
            mask_q  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            debnc   <= '0;
        end else if (wr_accept) begin
            case (wr_idx)
                REG_CTRL:  if (be_mask[0]) ctrl_en <= s_axi.wdata[0];
                REG_MASK:  mask_q  <= (mask_q  & ~N_CH'(be_mask))  | N_CH'(wr_bits);
                REG_RISE:  rise_en <= (rise_en & ~N_CH'(be_mask))  | N_CH'(wr_bits);
                REG_FALL:  fall_en <= (fall_en & ~N_CH'(be_mask))  | N_CH'(wr_bits);
                REG_DEBNC: debnc   <= (debnc   & ~CNT_W'(be_mask)) | CNT_W'(wr_bits);
                default:   ;
            endcase
        end
    end

    assign ev_set = (rise & rise_en) | (fall & fall_en);
    assign ev_w1c = (wr_accept && wr_idx == REG_EVENT) ? N_CH'(wr_bits) : '0;

    // Sticky events: a new edge wins over a simultaneous W1C; irq follows one cycle later.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            event_q <= '0;
            irq     <= 1'b0;
        end else begin
            event_q <= (event_q & ~ev_w1c) | ev_set;
            irq     <= ctrl_en & |(event_q & mask_q);
        end
    end

    // Read data selection for the captured read index.
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            REG_CTRL:  rd_mux = {31'b0, ctrl_en};
            REG_STATE: rd_mux = 32'(sw_state);
            REG_MASK:  rd_mux = 32'(mask_q);
            REG_EVENT: rd_mux = 32'(event_q);
            REG_RISE:  rd_mux = 32'(rise_en);
            REG_FALL:  rd_mux = 32'(fall_en);
            REG_DEBNC: rd_mux = 32'(debnc);
            REG_INFO:  rd_mux = {INFO_VERSION, 8'(CNT_W), 8'(N_CH)};
            default:   rd_mux = '0;
        endcase
    end

    // Capture read data in the accept cycle and hold it while rvalid waits for rready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                       rdata_q <= '0;
        else if (rd_state == RD_ACCEPT)   rdata_q <= rd_mux;
    end

endmodule

// File: tb/tb_switch_ctrlr_axil_n.sv
// Directed self-checking bench for switch_ctrlr_axil_n (N_CH=4, CNT_W=16).
module tb_switch_ctrlr_axil_n;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    localparam logic [4:0] A_CTRL  = 5'h00;
    localparam logic [4:0] A_STATE = 5'h04;
    localparam logic [4:0] A_MASK  = 5'h08;
    localparam logic [4:0] A_EVENT = 5'h0C;
    localparam logic [4:0] A_RISE  = 5'h10;
    localparam logic [4:0] A_FALL  = 5'h14;
    localparam logic [4:0] A_DEBNC = 5'h18;
    localparam logic [4:0] A_INFO  = 5'h1C;

    localparam logic [31:0] INFO_EXP = 32'h0002_1004;

    logic            aclk   = 1'b0;
    logic            areset = 1'b1;
    logic [N_CH-1:0] sw_in  = '0;
    logic [N_CH-1:0] sw_state;
    logic            irq;
    logic [31:0]     rd;
    int              checks = 0;
    int              errors = 0;

    switch_ctrlr_axil_n_if #(.ADDR_W(5)) bus ();

    switch_ctrlr_axil_n #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(5)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_axi    (bus),
        .sw_in    (sw_in),
        .sw_state (sw_state),
        .irq      (irq)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_bvalid();
        for (int n = 0; n < 20 && bus.bvalid !== 1'b1; n++) @(negedge aclk);
        check("wr_bvalid", 32'(bus.bvalid), 32'd1);
        check("wr_bresp", 32'(bus.bresp), 32'd0);
        @(posedge aclk);
        #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge aclk);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        for (int n = 0; n < 20 && bus.awready !== 1'b1; n++) @(negedge aclk);
        check("wr_accept", 32'(bus.awready & bus.wready), 32'd1);
        @(posedge aclk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_bvalid();
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        @(negedge aclk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        for (int n = 0; n < 20 && bus.arready !== 1'b1; n++) @(negedge aclk);
        check("rd_accept", 32'(bus.arready), 32'd1);
        @(posedge aclk);
        #1;
        bus.arvalid = 1'b0;
        for (int n = 0; n < 20 && bus.rvalid !== 1'b1; n++) @(negedge aclk);
        check("rd_rvalid", 32'(bus.rvalid), 32'd1);
        check("rd_rresp", 32'(bus.rresp), 32'd0);
        data = bus.rdata;
        @(posedge aclk);
        #1;
        bus.rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_outputs", 32'({sw_state, irq, bus.awready, bus.wready, bus.bvalid,
                                  bus.arready, bus.rvalid, bus.bresp, bus.rresp}), 32'd0);
        areset = 1'b0;

        // Reset asserted while awready is high clears outputs immediately
        @(negedge aclk);
        bus.awaddr  = A_CTRL;
        bus.wdata   = 32'h1;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int n = 0; n < 20 && bus.awready !== 1'b1; n++) @(negedge aclk);
        check("pre_rst_awready", 32'(bus.awready), 32'd1);
        #2 areset = 1'b1;
        #1;
        check("rst_async", 32'({bus.awready, bus.wready, bus.bvalid, irq, sw_state}), 32'd0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        read_check("info", A_INFO, INFO_EXP);
        read_check("ctrl_after_rst", A_CTRL, 32'd0);

        // Byte strobes and read-only offsets
        axi_write(A_DEBNC, 32'hFFFF_FFFF, 4'b0001);
        read_check("debnc_strb", A_DEBNC, 32'h0000_00FF);
        axi_write(A_INFO, 32'h1234_5678, 4'hF);
        read_check("info_ro", A_INFO, INFO_EXP);

        // Debounce with D=10: a 5-cycle glitch is rejected
        axi_write(A_DEBNC, 32'd10, 4'hF);
        @(negedge aclk);
        sw_in[0] = 1'b1;
        repeat (5) @(negedge aclk);
        sw_in[0] = 1'b0;
        repeat (20) @(negedge aclk);
        check("glitch_state", 32'(sw_state), 32'd0);

        // A held change appears exactly 2+11 cycles after the pin edge
        sw_in[0] = 1'b1;
        repeat (12) @(negedge aclk);
        check("deb_early", 32'(sw_state), 32'd0);
        @(negedge aclk);
        check("deb_exact", 32'(sw_state), 32'd1);
        repeat (7) @(negedge aclk);
        read_check("state_reg", A_STATE, 32'h1);

        // Events and irq with D=0
        axi_write(A_DEBNC, 32'd0, 4'hF);
        @(negedge aclk);
        sw_in = 4'b0010;
        repeat (8) @(negedge aclk);
        check("state_0010", 32'(sw_state), 32'h2);
        axi_write(A_RISE, 32'h1, 4'hF);
        axi_write(A_FALL, 32'h2, 4'hF);
        axi_write(A_MASK, 32'h3, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        read_check("event_idle", A_EVENT, 32'h0);
        check("irq_idle", 32'(irq), 32'd0);
        @(negedge aclk);
        sw_in = 4'b0001;
        repeat (8) @(negedge aclk);
        read_check("event_both", A_EVENT, 32'h3);
        check("irq_set", 32'(irq), 32'd1);
        axi_write(A_EVENT, 32'h1, 4'hF);
        read_check("event_w1c0", A_EVENT, 32'h2);
        check("irq_held", 32'(irq), 32'd1);
        axi_write(A_EVENT, 32'h2, 4'hF);
        repeat (2) @(negedge aclk);
        check("irq_cleared", 32'(irq), 32'd0);
        read_check("event_empty", A_EVENT, 32'h0);

        // W1C of bit0 in the same cycle a rising edge sets bit0
        @(negedge aclk);
        sw_in = 4'b0000;
        repeat (8) @(negedge aclk);
        read_check("event_pre_coll", A_EVENT, 32'h0);
        @(negedge aclk);
        sw_in[0] = 1'b1;
        repeat (2) @(negedge aclk);
        bus.awaddr  = A_EVENT;
        bus.wdata   = 32'h1;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        @(negedge aclk);
        check("coll_awready", 32'(bus.awready), 32'd1);
        @(posedge aclk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_bvalid();
        read_check("collision", A_EVENT, 32'h1);
        check("irq_coll", 32'(irq), 32'd1);

        // irq_en and mask gate the interrupt
        axi_write(A_CTRL, 32'h0, 4'hF);
        repeat (2) @(negedge aclk);
        check("irq_en_off", 32'(irq), 32'd0);
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) @(negedge aclk);
        check("irq_en_on", 32'(irq), 32'd1);
        axi_write(A_MASK, 32'h2, 4'hF);
        repeat (2) @(negedge aclk);
        check("irq_masked", 32'(irq), 32'd0);

        // Write response backpressure blocks a second write
        @(negedge aclk);
        bus.awaddr  = A_MASK;
        bus.wdata   = 32'h5;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        for (int n = 0; n < 20 && bus.awready !== 1'b1; n++) @(negedge aclk);
        check("bp_first_accept", 32'(bus.awready), 32'd1);
        @(posedge aclk);
        #1;
        bus.wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            check("bp_bvalid", 32'(bus.bvalid), 32'd1);
            check("bp_no_accept", 32'(bus.awready), 32'd0);
        end
        bus.bready = 1'b1;
        @(posedge aclk);
        #1;
        bus.bready = 1'b0;
        for (int n = 0; n < 20 && bus.awready !== 1'b1; n++) @(negedge aclk);
        check("bp_second_accept", 32'(bus.awready), 32'd1);
        bus.bready = 1'b1;
        @(posedge aclk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_bvalid();
        read_check("bp_mask", A_MASK, 32'hF);

        // Read data backpressure keeps rdata stable
        @(negedge aclk);
        bus.araddr  = A_MASK;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        for (int n = 0; n < 20 && bus.arready !== 1'b1; n++) @(negedge aclk);
        check("rbp_accept", 32'(bus.arready), 32'd1);
        @(posedge aclk);
        #1;
        bus.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("rbp_rvalid", 32'(bus.rvalid), 32'd1);
            check("rbp_rdata", bus.rdata, 32'hF);
        end
        bus.rready = 1'b1;
        @(posedge aclk);
        #1;
        check("rbp_done", 32'(bus.rvalid), 32'd0);
        bus.rready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
